// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS32-subset core: one clock, one shared req/ready memory port.
// Memory-port, retire and halt outputs are registers loaded with next-state values.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 16,
  parameter int          NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic              halted,
  output logic [31:0]       dbg_pc
);

  localparam int RIDX_W = (NUM_REGS <= 8) ? 3 : ((NUM_REGS <= 16) ? 4 : 5);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    case (op)
      OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                     (fn == FN_OR)  || (fn == FN_SLT);
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] alu(input logic [5:0] fn, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] r;
    case (fn)
      FN_ADD:  r = a + b;
      FN_SUB:  r = a - b;
      FN_AND:  r = a & b;
      FN_OR:   r = a | b;
      FN_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       simm_q, simm_d;
  logic [31:0]       pc4_q, pc4_d;
  logic [31:0]       res_q, res_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              retire_q, retire_d;
  logic              halted_q, halted_d;
  logic [31:0]       gpr_q [NUM_REGS];

  logic [5:0]        opcode_s, funct_s;
  logic [RIDX_W-1:0] rs_s, rt_s, rd_s;
  logic [31:0]       pc4_s, ea_s, npc_s;
  logic              retire_s;
  logic              rf_we_s;
  logic [RIDX_W-1:0] rf_waddr_s;
  logic [31:0]       rf_wdata_s;
  logic              unused_s;

  assign opcode_s = ir_q[31:26];
  assign funct_s  = ir_q[5:0];
  assign rs_s     = ir_q[21 +: RIDX_W];
  assign rt_s     = ir_q[16 +: RIDX_W];
  assign rd_s     = ir_q[11 +: RIDX_W];
  assign pc4_s    = pc_q + 32'd4;
  assign ea_s     = a_q + simm_q;
  assign unused_s = ^ir_q[10:6];

  // Next-state logic for the FETCH/DECODE/EXEC/MEM/WB/HALT sequencer.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    simm_d      = simm_q;
    pc4_d       = pc4_q;
    res_d       = res_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    retire_d    = 1'b0;
    halted_d    = halted_q;
    retire_s    = 1'b0;
    npc_s       = pc4_q;
    rf_we_s     = 1'b0;
    rf_waddr_s  = {RIDX_W{1'b0}};
    rf_wdata_s  = res_q;

    case (state_q)
      S_FETCH: begin
        if (mem_req_q && mem_ready) begin
          ir_d      = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = S_DECODE;
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q[ADDR_W-1:0];
        end
      end
      S_DECODE: begin
        a_d    = gpr_q[rs_s];
        b_d    = gpr_q[rt_s];
        simm_d = sext16(ir_q[15:0]);
        pc4_d  = pc4_s;
        if (!is_legal(opcode_s, funct_s)) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (opcode_s == OP_J) begin
          retire_s = 1'b1;
          npc_s    = {pc4_s[31:28], ir_q[25:0], 2'b00};
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode_s)
          OP_RTYPE: begin
            res_d   = alu(funct_s, a_q, b_q);
            state_d = S_WB;
          end
          OP_ADDI: begin
            res_d   = a_q + simm_q;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            res_d = ea_s;
            // A misaligned effective address halts before any bus activity.
            if (ea_s[1:0] != 2'b00) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end else begin
              state_d     = S_MEM;
              mem_req_d   = 1'b1;
              mem_we_d    = (opcode_s == OP_SW);
              mem_addr_d  = ea_s[ADDR_W-1:0];
              mem_wdata_d = b_q;
            end
          end
          OP_BEQ: begin
            retire_s = 1'b1;
            npc_s    = (a_q == b_q) ? (pc4_q + (simm_q << 2)) : pc4_q;
          end
          default: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (mem_req_q && mem_ready) begin
          if (mem_we_q) begin
            retire_s = 1'b1;
            npc_s    = pc4_q;
          end else begin
            res_d     = mem_rdata;
            mem_req_d = 1'b0;
            state_d   = S_WB;
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end
      S_WB: begin
        rf_waddr_s = (opcode_s == OP_RTYPE) ? rd_s : rt_s;
        rf_we_s    = (rf_waddr_s != {RIDX_W{1'b0}});
        retire_s   = 1'b1;
        npc_s      = pc4_q;
      end
      S_HALT: begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        halted_d  = 1'b1;
      end
      default: begin
        state_d   = S_HALT;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        halted_d  = 1'b1;
      end
    endcase

    // Retiring launches the next fetch in the same edge, so there is no bubble.
    if (retire_s) begin
      pc_d       = npc_s;
      retire_d   = 1'b1;
      state_d    = S_FETCH;
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = npc_s[ADDR_W-1:0];
    end else begin
      retire_d = 1'b0;
    end
  end

  // Sequencer, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 32'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      simm_q      <= 32'd0;
      pc4_q       <= 32'd0;
      res_q       <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= 32'd0;
      retire_q    <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      simm_q      <= simm_d;
      pc4_q       <= pc4_d;
      res_q       <= res_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      retire_q    <= retire_d;
      halted_q    <= halted_d;
    end
  end

  // Register file; entry 0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_q[i] <= 32'd0;
      end
    end else if (rf_we_s) begin
      gpr_q[rf_waddr_s] <= rf_wdata_s;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign retire    = retire_q;
  assign halted    = halted_q;
  assign dbg_pc    = pc_q;

endmodule
